// File: rtl/dict_finder.sv
// dict_finder: walks a linked dictionary looking for the next blank-delimited
// token of an input buffer.
//
// The token is located first (leading 0x20 skipped, length counted up to the
// first 0x20 or 0x00). Then the entry list is followed from the newest header.
// Each header is LSZ little-endian link bytes, then a length byte
// ([7] immediate, [6] hidden, [4:0] length), then the name bytes.
// Entries that are hidden or have the wrong length are passed over without
// reading their name. Every memory byte costs two cycles: an address cycle
// (ph=0, mem_re high) and a data cycle (ph=1, mem_d valid).
//
// Optional feature: define FINDER_CASE_FOLD_EN to fold ASCII lower case to
// upper case on both sides of the name comparison.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start, ctx, tib request pulse, newest header address, input buffer address
//   mem_a, mem_re   memory read address and strobe
//   mem_d           read data, valid the cycle after the strobe
//   busy, done      search in progress, one-cycle completion pulse
//   hit, imm, xt    match flag, immediate flag and parameter-field address
//   nxt, tlen, err  terminator address, token length, empty/overlong token
module dict_finder #(
    parameter int DSZ  = 8,
    parameter int ASZ  = 17,
    parameter int LSZ  = 2,
    parameter int NMAX = 31
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [ASZ-1:0] ctx,
    input  logic [ASZ-1:0] tib,
    output logic [ASZ-1:0] mem_a,
    output logic           mem_re,
    input  logic [DSZ-1:0] mem_d,
    output logic           busy,
    output logic           done,
    output logic           hit,
    output logic           imm,
    output logic [ASZ-1:0] xt,
    output logic [ASZ-1:0] nxt,
    output logic [4:0]     tlen,
    output logic           err
);

    localparam int             LW       = 8 * LSZ;
    localparam logic [ASZ-1:0] LSZ_A    = ASZ'(LSZ);
    localparam logic [1:0]     LNK_LAST = 2'(LSZ - 1);

    typedef enum logic [2:0] {IDLE, SKIP, SCAN, LNK, LEN, NAM, CMP, DONE} state_t;

    state_t         state, state_nx;
    logic           ph;
    logic [ASZ-1:0] ptr;
    logic [ASZ-1:0] tok_start;
    logic [ASZ-1:0] hdr;
    logic [5:0]     cnt;
    logic [1:0]     lidx;
    logic [LW-1:0]  lnk_raw;
    logic [ASZ-1:0] lnk_addr;
    logic [7:0]     len_byte;
    logic [7:0]     nbyte;
    logic [4:0]     nidx;
    logic [7:0]     rd;

    logic is_sp, is_nul, skip_ent, name_eq, last_name, scan_ovf, lnk_zero;
    logic fin_empty, fin_long, fin_miss, fin_hit, follow, tok_begin, scan_end;

    function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef FINDER_CASE_FOLD_EN
        fold = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
`else
        fold = b;
`endif
    endfunction

    // The link value is zero-extended (or truncated) to the address width.
    generate
        if (LW >= ASZ) begin : g_lnk_trunc
            assign lnk_addr = lnk_raw[ASZ-1:0];
        end else begin : g_lnk_ext
            assign lnk_addr = {{(ASZ-LW){1'b0}}, lnk_raw};
        end
    endgenerate

    assign rd        = mem_d[7:0];
    assign is_sp     = (rd == 8'h20);
    assign is_nul    = (rd == 8'h00);
    assign skip_ent  = rd[6] || (rd[4:0] != cnt[4:0]);
    assign name_eq   = (fold(rd) == fold(nbyte));
    assign last_name = (nidx == cnt[4:0] - 5'd1);
    assign scan_ovf  = (cnt >= 6'(NMAX));
    assign lnk_zero  = (lnk_raw == '0);

    // State register; reset abandons any search without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; all decisions taken on data cycles are flagged here
    // so the datapath below acts on exactly the same conditions.
    always_comb begin
        state_nx  = state;
        fin_empty = 1'b0;
        fin_long  = 1'b0;
        fin_miss  = 1'b0;
        fin_hit   = 1'b0;
        follow    = 1'b0;
        tok_begin = 1'b0;
        scan_end  = 1'b0;
        case (state)
            IDLE: if (start) state_nx = SKIP;
            SKIP: if (ph) begin
                if (is_nul) begin
                    fin_empty = 1'b1;
                    state_nx  = DONE;
                end else if (!is_sp) begin
                    tok_begin = 1'b1;
                    state_nx  = SCAN;
                end
            end
            SCAN: if (ph) begin
                if (is_sp || is_nul) begin
                    scan_end = 1'b1;
                    state_nx = LNK;
                end else if (scan_ovf) begin
                    fin_long = 1'b1;
                    state_nx = DONE;
                end
            end
            LNK: if (ph && lidx == LNK_LAST) state_nx = LEN;
            LEN: if (ph) begin
                if (skip_ent) begin
                    if (lnk_zero) begin
                        fin_miss = 1'b1;
                        state_nx = DONE;
                    end else begin
                        follow   = 1'b1;
                        state_nx = LNK;
                    end
                end else begin
                    state_nx = NAM;
                end
            end
            NAM: if (ph) state_nx = CMP;
            CMP: if (ph) begin
                if (!name_eq) begin
                    if (lnk_zero) begin
                        fin_miss = 1'b1;
                        state_nx = DONE;
                    end else begin
                        follow   = 1'b1;
                        state_nx = LNK;
                    end
                end else if (last_name) begin
                    fin_hit  = 1'b1;
                    state_nx = DONE;
                end else begin
                    state_nx = NAM;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode: busy excludes DONE so it falls with the done pulse.
    always_comb begin
        busy   = (state != IDLE) && (state != DONE);
        done   = (state == DONE);
        mem_re = busy && !ph;
        case (state)
            SKIP, SCAN: mem_a = ptr;
            LNK:        mem_a = hdr + ASZ'(lidx);
            LEN:        mem_a = hdr + LSZ_A;
            NAM:        mem_a = hdr + LSZ_A + ASZ'(1) + ASZ'(nidx);
            CMP:        mem_a = tok_start + ASZ'(nidx);
            default:    mem_a = '0;
        endcase
    end

    // Datapath and result registers. Results change only on the edge that
    // enters DONE, so they are valid with done and hold until the next one.
    // The phase bit toggles while a state re-reads and clears on any move.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph        <= 1'b0;
            ptr       <= '0;
            tok_start <= '0;
            hdr       <= '0;
            cnt       <= '0;
            lidx      <= '0;
            lnk_raw   <= '0;
            len_byte  <= '0;
            nbyte     <= '0;
            nidx      <= '0;
            hit       <= 1'b0;
            imm       <= 1'b0;
            err       <= 1'b0;
            xt        <= '0;
            nxt       <= '0;
            tlen      <= '0;
        end else begin
            ph <= (busy && state_nx == state) ? ~ph : 1'b0;

            if (state == IDLE && start) begin
                ptr <= tib;
                hdr <= ctx;
            end
            if (state == SKIP && ph && is_sp) ptr <= ptr + ASZ'(1);
            if (tok_begin) begin
                tok_start <= ptr;
                cnt       <= 6'd1;
                ptr       <= ptr + ASZ'(1);
            end
            if (state == SCAN && ph && !is_sp && !is_nul && !scan_ovf) begin
                cnt <= cnt + 6'd1;
                ptr <= ptr + ASZ'(1);
            end
            if (state == LNK && ph) begin
                lnk_raw <= lnk_raw | (LW'(rd) << (8 * lidx));
                lidx    <= lidx + 2'd1;
            end
            if (state == LEN && ph) begin
                len_byte <= rd;
                nidx     <= '0;
            end
            if (state == NAM && ph) nbyte <= rd;
            if (state == CMP && ph && name_eq) nidx <= nidx + 5'd1;
            if (scan_end || follow) begin
                lnk_raw <= '0;
                lidx    <= '0;
            end
            if (follow) hdr <= lnk_addr;

            if (fin_empty || fin_long || fin_miss || fin_hit) begin
                hit <= fin_hit;
                err <= fin_empty || fin_long;
                nxt <= ptr;
                imm <= fin_hit ? len_byte[7] : 1'b0;
                xt  <= fin_hit ? hdr + LSZ_A + ASZ'(1) + ASZ'(cnt[4:0]) : '0;
                if (fin_empty)     tlen <= 5'd0;
                else if (fin_long) tlen <= 5'(NMAX);
                else               tlen <= cnt[4:0];
            end
        end
    end

endmodule

// File: tb/tb_dict_finder.sv
// tb_dict_finder: directed vectors against a small byte memory holding three
// dictionary entries; expected results are pushed to a scoreboard queue and a
// monitor compares them when done pulses.
//   0x100 "DUP" link 0,     length 0x03
//   0x180 "DUP" link 0x100, length 0x43 (hidden)
//   0x300 "DRP" link 0x180, length 0x83 (immediate)
// The input buffer is always rewritten at 0x200 before each search.
module tb_dict_finder;

    localparam int ASZ = 17;

    logic           clk   = 1'b0;
    logic           rst   = 1'b1;
    logic           start = 1'b0;
    logic [ASZ-1:0] ctx   = '0;
    logic [ASZ-1:0] tib   = '0;
    logic [ASZ-1:0] mem_a;
    logic           mem_re;
    logic [7:0]     mem_d = 8'h00;
    logic           busy, done, hit, imm, err;
    logic [ASZ-1:0] xt, nxt;
    logic [4:0]     tlen;

    dict_finder dut (
        .clk(clk), .rst(rst), .start(start), .ctx(ctx), .tib(tib),
        .mem_a(mem_a), .mem_re(mem_re), .mem_d(mem_d),
        .busy(busy), .done(done), .hit(hit), .imm(imm),
        .xt(xt), .nxt(nxt), .tlen(tlen), .err(err)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:(1<<ASZ)-1];

    // Memory answers one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_re) mem_d <= mem[mem_a];
    end

    typedef struct {
        int             tag;
        logic           hit;
        logic           imm;
        logic           err;
        logic [ASZ-1:0] xt;
        logic [ASZ-1:0] nxt;
        logic [4:0]     tlen;
        bit             chkImm;
        bit             chkXt;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   doneCount = 0;
    int   nameReads = 0;
    bit   prevDone  = 1'b0;

    task automatic checkOutput(input string nm, input int tag,
                               input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s (vector %0d): got 0x%0h, required 0x%0h", nm, tag, act, req);
        end
    endtask

    // Any read of a name byte of the 0x100 or 0x180 entries.
    always @(posedge clk) begin
        if (mem_re && ((mem_a >= 17'h103 && mem_a <= 17'h105) ||
                       (mem_a >= 17'h183 && mem_a <= 17'h185)))
            nameReads++;
    end

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (rst) begin
            prevDone = 1'b0;
        end else begin
            if (done) begin
                exp_t e;
                doneCount++;
                checkOutput("donePulseWidth", -1, 32'(prevDone), 0);
                checkOutput("busyLowAtDone", -1, 32'(busy), 0);
                checkOutput("doneExpected", -1, 32'(sbq.size() > 0), 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    checkOutput("hit", e.tag, 32'(hit), 32'(e.hit));
                    checkOutput("err", e.tag, 32'(err), 32'(e.err));
                    checkOutput("nxt", e.tag, 32'(nxt), 32'(e.nxt));
                    checkOutput("tlen", e.tag, 32'(tlen), 32'(e.tlen));
                    if (e.chkImm) checkOutput("imm", e.tag, 32'(imm), 32'(e.imm));
                    if (e.chkXt)  checkOutput("xt", e.tag, 32'(xt), 32'(e.xt));
                end
            end
            prevDone = done;
        end
    end

    task automatic setTib(input string s);
        for (int k = 0; k < s.len(); k++) mem[17'h200 + k] = s[k];
        mem[17'h200 + s.len()] = 8'h00;
    endtask

    // Issues one search; with poke set, a second start arrives mid-search
    // aimed at a buffer that would yield an error if it were accepted.
    task automatic applyStimulus(input int tag, input logic [ASZ-1:0] c, input string tok,
                                 input bit poke, input logic h, input logic i, input logic e,
                                 input logic [ASZ-1:0] x, input logic [ASZ-1:0] n,
                                 input logic [4:0] t, input bit ci, input bit cx);
        exp_t ex;
        setTib(tok);
        ex.tag = tag; ex.hit = h; ex.imm = i; ex.err = e;
        ex.xt = x; ex.nxt = n; ex.tlen = t; ex.chkImm = ci; ex.chkXt = cx;
        sbq.push_back(ex);
        @(negedge clk);
        start = 1'b1; ctx = c; tib = 17'h200;
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            repeat (3) @(negedge clk);
            start = 1'b1; ctx = 17'h300; tib = 17'h000;
            @(negedge clk);
            start = 1'b0;
        end
        for (int cyc = 0; cyc < 3000 && sbq.size() != 0; cyc++) @(negedge clk);
        checkOutput("timeout", tag, 32'(sbq.size()), 0);
        sbq.delete();
        @(negedge clk);
    endtask

    initial begin
        string longTok;
        int    saved;
        bit    seenNam, found;

        for (int k = 0; k < (1<<ASZ); k++) mem[k] = 8'h00;
        mem[17'h100] = 8'h00; mem[17'h101] = 8'h00; mem[17'h102] = 8'h03;
        mem[17'h103] = "D";   mem[17'h104] = "U";   mem[17'h105] = "P";
        mem[17'h180] = 8'h00; mem[17'h181] = 8'h01; mem[17'h182] = 8'h43;
        mem[17'h183] = "D";   mem[17'h184] = "U";   mem[17'h185] = "P";
        mem[17'h300] = 8'h80; mem[17'h301] = 8'h01; mem[17'h302] = 8'h83;
        mem[17'h303] = "D";   mem[17'h304] = "R";   mem[17'h305] = "P";

        repeat (3) @(negedge clk);
        checkOutput("rstBusy", 0, 32'(busy), 0);
        checkOutput("rstDone", 0, 32'(done), 0);
        checkOutput("rstHit", 0, 32'(hit), 0);
        checkOutput("rstImm", 0, 32'(imm), 0);
        checkOutput("rstErr", 0, 32'(err), 0);
        checkOutput("rstMemRe", 0, 32'(mem_re), 0);
        checkOutput("rstMemA", 0, 32'(mem_a), 0);
        checkOutput("rstXt", 0, 32'(xt), 0);
        checkOutput("rstNxt", 0, 32'(nxt), 0);
        checkOutput("rstTlen", 0, 32'(tlen), 0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(1, 17'h100, "  DUP ", 1'b1, 1, 0, 0, 17'h106, 17'h205, 5'd3, 1, 1);
        repeat (5) @(negedge clk);
        checkOutput("holdHit", 1, 32'(hit), 1);
        checkOutput("holdXt", 1, 32'(xt), 32'h106);

        applyStimulus(2, 17'h100, "SWAP", 1'b0, 0, 0, 0, 17'h000, 17'h204, 5'd4, 0, 0);
        applyStimulus(3, 17'h180, "DUP", 1'b0, 1, 0, 0, 17'h106, 17'h203, 5'd3, 1, 1);

        nameReads = 0;
        applyStimulus(4, 17'h180, "DU", 1'b0, 0, 0, 0, 17'h000, 17'h202, 5'd2, 0, 0);
        checkOutput("nameReads", 4, 32'(nameReads), 0);

`ifdef FINDER_CASE_FOLD_EN
        applyStimulus(5, 17'h100, "dup ", 1'b0, 1, 0, 0, 17'h106, 17'h203, 5'd3, 1, 1);
`else
        applyStimulus(5, 17'h100, "dup ", 1'b0, 0, 0, 0, 17'h000, 17'h203, 5'd3, 0, 0);
`endif

        applyStimulus(6, 17'h100, "   ", 1'b0, 0, 0, 1, 17'h000, 17'h203, 5'd0, 0, 0);

        longTok = "";
        for (int k = 0; k < 40; k++) longTok = {longTok, "A"};
        setTib(longTok);
        begin
            exp_t ex;
            ex.tag = 7; ex.hit = 0; ex.imm = 0; ex.err = 1; ex.xt = '0;
            ex.nxt = 17'h21F; ex.tlen = 5'd31; ex.chkImm = 0; ex.chkXt = 0;
            sbq.push_back(ex);
            @(negedge clk);
            start = 1'b1; ctx = 17'h100; tib = 17'h200;
            @(negedge clk);
            start = 1'b0;
            for (int cyc = 0; cyc < 3000 && sbq.size() != 0; cyc++) @(negedge clk);
            checkOutput("timeout", 7, 32'(sbq.size()), 0);
            sbq.delete();
            @(negedge clk);
        end

        applyStimulus(8, 17'h300, "DUP", 1'b0, 1, 0, 0, 17'h106, 17'h203, 5'd3, 1, 1);
        applyStimulus(9, 17'h300, "DRP", 1'b0, 1, 1, 0, 17'h306, 17'h203, 5'd3, 1, 1);

        // Abort a search in its compare phase and confirm it leaves no trace.
        setTib("  DUP ");
        saved = doneCount;
        @(negedge clk);
        start = 1'b1; ctx = 17'h100; tib = 17'h200;
        @(negedge clk);
        start = 1'b0;
        seenNam = 1'b0;
        found   = 1'b0;
        for (int cyc = 0; cyc < 500 && !found; cyc++) begin
            @(negedge clk);
            if (mem_re && mem_a == 17'h103) seenNam = 1'b1;
            else if (seenNam && mem_re && mem_a == 17'h202) found = 1'b1;
        end
        checkOutput("reachCmp", 10, 32'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("busyAfterReset", 10, 32'(busy), 0);
        checkOutput("memReAfterReset", 10, 32'(mem_re), 0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        checkOutput("noDoneAfterAbort", 10, doneCount, saved);

        applyStimulus(11, 17'h100, "  DUP ", 1'b0, 1, 0, 0, 17'h106, 17'h205, 5'd3, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dict_finder.md
DICT_FINDER -- requirements
Module: dict_finder

Interface
REQ-001 SHALL have parameter DSZ, default 8, memory data width in bits.
REQ-002 SHALL have parameter ASZ, default 17, memory address width in bits.
REQ-003 SHALL have parameter LSZ, default 2, number of link-field bytes per header (1..3).
REQ-004 SHALL have parameter NMAX, default 31, longest legal name in bytes (at most 31).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to find; ignored while busy.
REQ-008 SHALL have port ctx, input, ASZ, header address of the newest dictionary entry; sampled with start.
REQ-009 SHALL have port tib, input, ASZ, address of the first input byte; sampled with start.
REQ-010 SHALL have port mem_a, output, ASZ, memory read address.
REQ-011 SHALL have port mem_re, output, 1, memory read strobe.
REQ-012 SHALL have port mem_d, input, DSZ, read data, valid the cycle after mem_a/mem_re.
REQ-013 SHALL have port busy, output, 1, search in progress.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port hit, output, 1, token matched an entry.
REQ-016 SHALL have port imm, output, 1, immediate flag of the matched entry.
REQ-017 SHALL have port xt, output, ASZ, parameter-field address of the matched entry.
REQ-018 SHALL have port nxt, output, ASZ, address of the byte that terminated the token.
REQ-019 SHALL have port tlen, output, 5, token length.
REQ-020 SHALL have port err, output, 1, token empty or longer than NMAX.

Function
REQ-021 Header layout SHALL be: LSZ link bytes little-endian (value 0 = end of list), then a length byte ([7] immediate, [6] hidden, [4:0] length), then the name bytes; the parameter field follows the name.
REQ-022 States SHALL be IDLE, SKIP, SCAN, LNK, LEN, NAM, CMP, DONE.
REQ-023 IDLE to SKIP on start; busy SHALL rise the cycle after start and fall in the same cycle done pulses.
REQ-024 SKIP SHALL advance past 0x20 bytes; on 0x00 it SHALL go to DONE with err=1, hit=0, tlen=0, nxt=address of the 0x00 byte.
REQ-025 SCAN SHALL count bytes until 0x20 or 0x00, recording the token start address, tlen, and nxt = terminator address; a count above NMAX SHALL go to DONE with err=1, hit=0, tlen=NMAX.
REQ-026 LNK SHALL read LSZ link bytes, zero-extended to ASZ; LEN SHALL read the length byte.
REQ-027 An entry with hidden=1 or length != tlen SHALL be skipped with no name reads (follow link to LNK).
REQ-028 NAM/CMP SHALL alternate: read name byte, read token byte, compare; the first mismatch skips the entry; all tlen bytes equal SHALL go to DONE with hit=1, imm=[7], xt = header + LSZ + 1 + tlen.
REQ-029 After a skipped entry, a link of 0 SHALL go to DONE with hit=0, err=0.
REQ-030 Each memory byte SHALL take at most 2 cycles; mem_re SHALL be low in IDLE and DONE.
REQ-031 DONE SHALL pulse done for exactly one cycle, then return to IDLE.
REQ-032 hit, imm, xt, nxt, tlen and err SHALL be updated only at DONE and SHALL hold until the next DONE.
REQ-033 start while busy SHALL be ignored and SHALL NOT alter the search.
REQ-034 Address arithmetic SHALL wrap modulo 2^ASZ.

Reset
REQ-035 rst SHALL force IDLE on the next edge from any state, including mid-search.
REQ-036 On reset, busy, done, hit, imm, err, mem_re SHALL be 0, and xt, nxt, mem_a SHALL be all zeros with tlen 0.
REQ-037 A search aborted by reset SHALL NOT produce done.

Configuration
REQ-038 With FINDER_CASE_FOLD_EN defined, both compared bytes SHALL map 0x61-0x7A to 0x41-0x5A before comparison.
REQ-039 Without FINDER_CASE_FOLD_EN, comparison SHALL be exact byte equality.

Verification
REQ-040 Entry "DUP" at 0x100 (link 0, length 0x03); tib 0x200 = "  DUP " -> hit=1, imm=0, xt=0x106, nxt=0x205, tlen=3, err=0.
REQ-041 Same dictionary; tib = "SWAP",0x00 -> hit=0, err=0, tlen=4, nxt=0x204, one done pulse.
REQ-042 Newest entry "DUP" hidden (0x43) at 0x180 linking to 0x100; tib "DUP" -> hit=1, xt=0x106; token "DU" -> hit=0 with no name reads of either entry.
REQ-043 tib "dup " with FINDER_CASE_FOLD_EN -> hit=1, xt=0x106; without it -> hit=0.
REQ-044 tib = "   ",0x00 -> err=1, tlen=0, hit=0; a 40-byte token -> err=1, tlen=31.
REQ-045 rst during CMP -> busy=0 next cycle and no done pulse; a following start completes normally.
